fixed_point_mac_pipe: RTL and testbench
=======================================

// Module: fixed_point_mac_pipe
// PURPOSE
//  Pipelined signed fixed-point arithmetic unit for the CNN datapath: ADD, MUL, or multiply-accumulate (MAC) over a burst.
//  Results are rounded and saturated back to the input Q format.
//  Sits between the weight/feature fetch logic and the conv/activation stage; valid/ready on both sides.
// PARAMETERS
//  WIDTH        32  total operand/result width, two's complement
//  POINT_WIDTH  16  fractional bits (Q(WIDTH-POINT_WIDTH).POINT_WIDTH); 1 <= POINT_WIDTH < WIDTH
//  GUARD        8   accumulator guard bits; MAC exact for up to 2^GUARD beats
// PORTS
//  clk        in   1        clock, all logic on rising edge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        operand beat valid
//  in_ready   out  1        unit can accept a beat this cycle
//  in_mode    in   2        0=ADD 1=MUL 2=MAC 3=reserved (treated as ADD)
//  in_first   in   1        MAC: first beat of burst (clears accumulator)
//  in_last    in   1        MAC: last beat of burst (emits result)
//  a          in   WIDTH    signed operand A
//  b          in   WIDTH    signed operand B
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accepts result
//  out_data   out  WIDTH    signed rounded/saturated result
//  out_sat    out  1        result was clipped by saturation
// BEHAVIOUR
//  - Reset: all stage valids, accumulator, out_valid, out_data, out_sat = 0.
//    Reset mid-burst drops in-flight beats and the partial sum; no output is produced for them.
//  - Handshake: beat accepted when in_valid && in_ready. Result transfers when out_valid && out_ready.
//  - Stall: en = !(out_valid && !out_ready); in_ready = en. When en=0 the whole pipe freezes.
//    out_data, out_sat and out_valid hold stable while stalled. No combinational in->out path except in_ready.
//  - Latency: 3 cycles from accept to out_valid (S1 operand reg, S2 multiply/add/accumulate, S3 round/sat reg).
//    Throughput: 1 beat/cycle.
//  - ADD: sum = sext(a)+sext(b) at WIDTH+1 bits; no shift; saturate to WIDTH. One result per beat.
//  - MUL: p = a*b at 2*WIDTH bits (2*POINT_WIDTH frac bits).
//    r = (p + 2^(POINT_WIDTH-1)) >>> POINT_WIDTH (round half up, arithmetic shift); saturate to WIDTH. One result per beat.
//  - MAC: ACC_W = 2*WIDTH+GUARD bits, full-precision products.
//    first=1: acc <= sext(p). first=0: acc <= acc + sext(p).
//    Emits only on the beat with last=1, rounded/saturated like MUL. first&&last: single-product result.
//    Non-last MAC beats produce no output. Overflow beyond ACC_W wraps (caller keeps bursts <= 2^GUARD).
//  - MAC beat with first=0 and no open burst (after reset or after last): accumulates onto the stale/zero acc.
//    Legal, not flagged.
//  - ADD/MUL beats interleaved inside a MAC burst do not touch acc.
//  - Saturation: if the value exceeds 2^(WIDTH-1)-1 -> 0x7F..F; if below -2^(WIDTH-1) -> 0x80..0.
//    out_sat=1 with that result, else 0.
//  - in_first/in_last are ignored for ADD/MUL.
// STRUCTURE
//  - Shared package fixp_pkg: MODE_ADD/MODE_MUL/MODE_MAC constants; function acc_width(WIDTH,GUARD).
//  - Sub-module fixp_round_sat (combinational): params IN_W, OUT_W, SHIFT; ports value_in, data_out, sat_out.
//    Instanced once, feeding the S3 register.
//  - Top: S1/S2/S3 valid+payload regs, one shared enable, accumulator reg in S2. Multiplier is inferred (DSP).
// TESTING  (WIDTH=32, POINT_WIDTH=16, GUARD=8)
//  1 MUL a=0x00018000 (1.5), b=0x00020000 (2.0) -> 3 cycles later out_data=0x00030000, out_sat=0.
//  2 ADD a=0x7FFF0000, b=0x00020000 -> out_data=0x7FFFFFFF, out_sat=1.
//    ADD a=0x80000000, b=0xFFFFFFFF -> out_data=0x80000000, out_sat=1.
//  3 MUL rounding: a=0x00000001, b=0x00008000 -> 0x00000001.
//    a=0xFFFFFFFF, b=0x00008000 -> 0x00000000.
//  4 MAC 4 beats a=0x00010000, b=0x00008000, first on beat0, last on beat3, back-to-back
//    -> exactly one out_valid pulse, out_data=0x00020000. first&&last single beat 0.5*0.5 -> 0x00004000.
//  5 Back-to-back MUL stream with out_ready=0 for 3 cycles -> in_ready=0 after pipe fills; outputs held stable.
//    No beat lost or duplicated (scoreboard order preserved).
//  6 rst=1 for 1 cycle mid-MAC burst (2 of 4 beats in) -> out_valid=0 next cycle.
//    New burst 1.0*1.0 x2 -> 0x00020000, no carry-over from the aborted burst.

Source files
------------

// File: rtl/fixp_pkg.sv
// Shared definitions for the signed fixed-point MAC pipeline.
package fixp_pkg;

    // Operation select carried alongside each operand beat.
    typedef enum logic [1:0] {
        MODE_ADD = 2'd0,
        MODE_MUL = 2'd1,
        MODE_MAC = 2'd2,
        MODE_RSV = 2'd3   // reserved, executes as ADD
    } mode_t;

    // Accumulator width: full-precision product plus guard bits for burst growth.
    function automatic int acc_width(input int width, input int guard);
        return 2 * width + guard;
    endfunction

endpackage

// File: rtl/fixp_round_sat.sv
// Round-half-up, arithmetic right shift by SHIFT, then saturate IN_W -> OUT_W.
module fixp_round_sat #(
    parameter int IN_W  = 72,
    parameter int OUT_W = 32,
    parameter int SHIFT = 16
) (
    input  logic signed [IN_W-1:0] value_in,
    output logic [OUT_W-1:0]       data_out,
    output logic                   sat_out
);

    // One extra bit so adding the rounding constant can never wrap.
    localparam logic signed [IN_W:0] HALF    = (IN_W+1)'(1) <<< (SHIFT - 1);
    localparam logic [OUT_W-1:0]     MAX_VAL = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]     MIN_VAL = {1'b1, {(OUT_W-1){1'b0}}};

    logic signed [IN_W:0]   biased;
    logic signed [IN_W:0]   shifted;
    logic [IN_W-OUT_W+1:0]  upper;

    // Round, shift and clip; the value fits when all bits above the output sign agree.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
        biased   = $signed({value_in[IN_W-1], value_in}) + HALF;
        shifted  = biased >>> SHIFT;
        upper    = shifted[IN_W:OUT_W-1];
        sat_out  = !((&upper) || !(|upper));
        data_out = shifted[OUT_W-1:0];
        if (sat_out) begin
            data_out = shifted[IN_W] ? MIN_VAL : MAX_VAL;
        end
    end

endmodule

// File: rtl/fixed_point_mac_pipe.sv
// Three-stage signed fixed-point ADD / MUL / MAC unit with valid/ready on both sides.
// S1 registers operands, S2 computes (and owns the accumulator), S3 holds the rounded result.
module fixed_point_mac_pipe
    import fixp_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int POINT_WIDTH = 16,
    parameter int GUARD       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic             in_first,
    input  logic             in_last,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sat
);

    localparam int ACC_W = acc_width(WIDTH, GUARD);

    // Single pipe-wide enable: everything freezes while a result waits downstream.
    logic en;
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    // Stage 1 operand registers.
    logic                    s1_valid;
    mode_t                   s1_mode;
    logic                    s1_first;
    logic                    s1_last;
    logic signed [WIDTH-1:0] s1_a;
    logic signed [WIDTH-1:0] s1_b;

    // Stage 2 result at ACC_W bits with 2*POINT_WIDTH fraction bits, plus accumulator.
    logic             s2_valid;
    logic [ACC_W-1:0] s2_value;
    logic [ACC_W-1:0] acc;

    logic signed [2*WIDTH-1:0] prod;
    logic [WIDTH:0]            sum;
    logic [ACC_W-1:0]          prod_ext;
    logic [ACC_W-1:0]          add_ext;
    logic [ACC_W-1:0]          mac_next;
    logic [ACC_W-1:0]          s2_next;

    logic [WIDTH-1:0] rs_data;
    logic             rs_sat;

    // Stage 2 datapath: ADD is aligned to the product's fraction point so one rounder serves all modes.
    always_comb begin
        prod     = s1_a * s1_b;
        sum      = {s1_a[WIDTH-1], s1_a} + {s1_b[WIDTH-1], s1_b};
        prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
        add_ext  = {{(ACC_W-WIDTH-1-POINT_WIDTH){sum[WIDTH]}}, sum, {POINT_WIDTH{1'b0}}};
        mac_next = s1_first ? prod_ext : acc + prod_ext;
        case (s1_mode)
            MODE_MUL: s2_next = prod_ext;
            MODE_MAC: s2_next = mac_next;
            default:  s2_next = add_ext;
        endcase
    end

    fixp_round_sat #(
        .IN_W  (ACC_W),
        .OUT_W (WIDTH),
        .SHIFT (POINT_WIDTH)
    ) u_round_sat (
        .value_in (s2_value),
        .data_out (rs_data),
        .sat_out  (rs_sat)
    );

    // Control and architecturally visible state: valids, accumulator, output register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            s1_valid  <= in_valid;
            // Non-last MAC beats only update the accumulator; they never reach the output.
            s2_valid  <= s1_valid && (s1_mode != MODE_MAC || s1_last);
            if (s1_valid && s1_mode == MODE_MAC) begin
                acc <= mac_next;
            end
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_data <= rs_data;
                out_sat  <= rs_sat;
            end
        end
    end

    // Payload registers, qualified by the stage valids above.
    always_ff @(posedge clk) begin
        // NOTE: payload registers carry no reset; their valid bits decide whether they are ever observed.
        if (en) begin
            if (in_valid) begin
                s1_mode  <= mode_t'(in_mode);
                s1_first <= in_first;
                s1_last  <= in_last;
                s1_a     <= a;
                s1_b     <= b;
            end
            if (s1_valid) begin
                s2_value <= s2_next;
            end
        end
    end

endmodule

// File: tb/tb_fixed_point_mac_pipe.sv
// Directed self-checking bench for fixed_point_mac_pipe (WIDTH=32, POINT_WIDTH=16, GUARD=8).
module tb_fixed_point_mac_pipe;

    localparam logic [1:0] M_ADD = 2'd0;
    localparam logic [1:0] M_MUL = 2'd1;
    localparam logic [1:0] M_MAC = 2'd2;
    localparam logic [1:0] M_RSV = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic        in_first;
    logic        in_last;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sat;

    int n_checks = 0;
    int n_fail   = 0;
    int n_xfer   = 0;

    logic [32:0] exp_q[$];   // {sat, data} in expected output order

    fixed_point_mac_pipe #(
        .WIDTH       (32),
        .POINT_WIDTH (16),
        .GUARD       (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_first  (in_first),
        .in_last   (in_last),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_out(input logic [31:0] data, input logic sat);
        exp_q.push_back({sat, data});
    endtask

    // Present one beat and hold it until it is accepted (in_ready sampled before the edge).
    task automatic beat(input logic [1:0] mode, input logic first, input logic last,
                        input logic [31:0] av, input logic [31:0] bv);
        logic acc_ok;
        int   guard;
        guard    = 0;
        in_valid = 1'b1;
        in_mode  = mode;
        in_first = first;
        in_last  = last;
        a        = av;
        b        = bv;
        do begin
            @(negedge clk);
            acc_ok = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc_ok && guard < 50);
        if (!acc_ok) check("beat_accept_timeout", 64'(acc_ok), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Scoreboard: a transfer happens at the next rising edge when valid and ready are both high here.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                check("unexpected_output", {32'd0, out_data}, 64'hDEAD_BEEF);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("out_data", {32'd0, out_data}, {32'd0, e[31:0]});
                check("out_sat", 64'(out_sat), 64'(e[32]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] held;
        int          xfer_before;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = M_ADD;
        in_first  = 1'b0;
        in_last   = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", {32'd0, out_data}, 64'd0);
        check("rst_out_sat", 64'(out_sat), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // 1: MUL 1.5 * 2.0 = 3.0, visible three edges after acceptance
        expect_out(32'h0003_0000, 1'b0);
        beat(M_MUL, 1'b0, 1'b0, 32'h0001_8000, 32'h0002_0000);
        check("lat_c1_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_c2_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_c3_valid", 64'(out_valid), 64'd1);
        check("lat_c3_data", {32'd0, out_data}, 64'h0003_0000);
        drain();

        // 2: ADD saturation both ways, plus reserved mode behaving as ADD
        expect_out(32'h7FFF_FFFF, 1'b1);
        expect_out(32'h8000_0000, 1'b1);
        expect_out(32'h0002_0000, 1'b0);
        beat(M_ADD, 1'b0, 1'b0, 32'h7FFF_0000, 32'h0002_0000);
        beat(M_ADD, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        beat(M_RSV, 1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000);
        drain();

        // 3: MUL rounding half up, and MUL saturation
        expect_out(32'h0000_0001, 1'b0);
        expect_out(32'h0000_0000, 1'b0);
        expect_out(32'h7FFF_FFFF, 1'b1);
        expect_out(32'h8000_0000, 1'b1);
        beat(M_MUL, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_8000);
        beat(M_MUL, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_8000);
        beat(M_MUL, 1'b0, 1'b0, 32'h7FFF_0000, 32'h0002_0000);
        beat(M_MUL, 1'b0, 1'b0, 32'h8000_0000, 32'h0002_0000);
        drain();

        // 4: MAC burst 4 x (1.0*0.5) = 2.0 with a single output, then first&&last 0.5*0.5
        xfer_before = n_xfer;
        expect_out(32'h0002_0000, 1'b0);
        beat(M_MAC, 1'b1, 1'b0, 32'h0001_0000, 32'h0000_8000);
        beat(M_MAC, 1'b0, 1'b0, 32'h0001_0000, 32'h0000_8000);
        beat(M_MAC, 1'b0, 1'b0, 32'h0001_0000, 32'h0000_8000);
        beat(M_MAC, 1'b0, 1'b1, 32'h0001_0000, 32'h0000_8000);
        drain();
        check("mac_one_pulse", 64'(n_xfer - xfer_before), 64'd1);
        expect_out(32'h0000_4000, 1'b0);
        beat(M_MAC, 1'b1, 1'b1, 32'h0000_8000, 32'h0000_8000);
        drain();

        // ADD inside a MAC burst leaves the accumulator alone: 1.0 + (1.0*2.0) = 3.0
        expect_out(32'h0002_0000, 1'b0);
        expect_out(32'h0003_0000, 1'b0);
        beat(M_MAC, 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        beat(M_ADD, 1'b1, 1'b1, 32'h0001_0000, 32'h0001_0000);
        beat(M_MAC, 1'b0, 1'b1, 32'h0001_0000, 32'h0002_0000);
        drain();

        // 5: MUL stream i*3.0 with downstream stalled; outputs must hold and nothing is lost
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) expect_out(32'(i * 3) << 16, 1'b0);
        fork
            begin
                for (int i = 1; i <= 6; i++) beat(M_MUL, 1'b0, 1'b0, 32'(i) << 16, 32'h0003_0000);
            end
            begin
                int g;
                g = 0;
                while (!out_valid && g < 20) begin
                    @(posedge clk); #1;
                    g++;
                end
                check("stall_fill", 64'(out_valid), 64'd1);
                held = out_data;
                check("stall_first", {32'd0, held}, 64'h0003_0000);
                repeat (3) begin
                    @(posedge clk); #1;
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                    check("stall_valid", 64'(out_valid), 64'd1);
                    check("stall_hold", {32'd0, out_data}, {32'd0, held});
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // 6: reset after 2 of 4 MAC beats drops the burst and the partial sum
        beat(M_MAC, 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        beat(M_MAC, 1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (3) begin
            @(posedge clk); #1;
            check("midrst_quiet", 64'(out_valid), 64'd0);
        end
        // Open-less MAC beat accumulates onto the cleared accumulator: 0 + 1.0
        expect_out(32'h0001_0000, 1'b0);
        beat(M_MAC, 1'b0, 1'b1, 32'h0001_0000, 32'h0001_0000);
        drain();
        expect_out(32'h0002_0000, 1'b0);
        beat(M_MAC, 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        beat(M_MAC, 1'b0, 1'b1, 32'h0001_0000, 32'h0001_0000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
